// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that shares one 2^AW x WIDTH register bank between two requesters.
// Define REG_BANK_ARBITER_PARITY_EN to add per-entry even parity with par_inj / perr.
//   state | meaning
//   IDLE  | no owner; arbitrate and capture winner's request on req
//   BUSY  | winner owns bank; access happens at the edge leaving this state
//   ACK   | winner owns bank; ack pulse of the winner is high
module reg_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req0,
  input  logic             wr0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             req1,
  input  logic             wr1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
`ifdef REG_BANK_ARBITER_PARITY_EN
  ,
  input  logic             par_inj,
  output logic             perr
`endif
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             win_q, win_d;
  logic             last_q, last_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic             pick;

  // Tie goes to whoever did not win last; otherwise the lone requester wins.
  assign pick = (req0 && req1) ? ~last_q : req1;

`ifdef REG_BANK_ARBITER_PARITY_EN
  logic             inj_q, inj_d;
  logic             par_q [DEPTH];
  logic             perr_q;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef REG_BANK_ARBITER_PARITY_EN
    inj_d   = inj_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_BUSY;
          win_d   = pick;
          last_d  = pick;
          wr_d    = pick ? wr1    : wr0;
          addr_d  = pick ? addr1  : addr0;
          wdata_d = pick ? wdata1 : wdata0;
`ifdef REG_BANK_ARBITER_PARITY_EN
          inj_d   = par_inj;
`endif
        end
      end
      ST_BUSY: state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef REG_BANK_ARBITER_PARITY_EN
      inj_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef REG_BANK_ARBITER_PARITY_EN
      inj_q   <= inj_d;
`endif
    end
  end

  // Storage and read data update on the edge that leaves BUSY.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
      rdata_q <= '0;
    end else if (state_q == ST_BUSY) begin
      if (wr_q) begin
        bank_q[addr_q] <= wdata_q;
      end else begin
        rdata_q <= bank_q[addr_q];
      end
    end
  end

`ifdef REG_BANK_ARBITER_PARITY_EN
  // Stored bit makes data+parity even; injection flips it to model a corrupted entry.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= 1'b0;
      end
      perr_q <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      if (wr_q) begin
        par_q[addr_q] <= (^wdata_q) ^ inj_q;
        perr_q        <= 1'b0;
      end else begin
        perr_q        <= (^bank_q[addr_q]) ^ par_q[addr_q];
      end
    end
  end

  assign perr = perr_q;
`endif

  assign busy  = (state_q != ST_IDLE);
  assign gnt0  = busy && !win_q;
  assign gnt1  = busy && win_q;
  assign ack0  = (state_q == ST_ACK) && !win_q;
  assign ack1  = (state_q == ST_ACK) && win_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: a transaction-level model predicts grant order and
// read data per burst; a negedge monitor checks every ack against the expected queue.
module tb_reg_bank_arbiter;
  localparam int WIDTH = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic             wr;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic             inj;
  } op_t;

  typedef struct {
    logic             who;
    logic [WIDTH-1:0] rdata;
    logic             perr;
  } exp_t;

  logic             clock = 1'b0;
  logic             clear = 1'b0;
  logic             req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0]    addr0 = '0, addr1 = '0;
  logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic             gnt0, gnt1, ack0, ack1, busy;
  logic [WIDTH-1:0] rdata;
`ifdef REG_BANK_ARBITER_PARITY_EN
  logic             par_inj = 1'b0;
  logic             perr;
`endif

  int vectors = 0;
  int miscompares = 0;

  op_t  ops0[$], ops1[$];
  exp_t expq[$];

  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_bad [DEPTH];
  logic             m_last;
  logic [WIDTH-1:0] m_rdata;
  logic             m_perr;

  reg_bank_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clock  (clock),
    .clear  (clear),
    .req0   (req0),
    .wr0    (wr0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .req1   (req1),
    .wr1    (wr1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .ack0   (ack0),
    .ack1   (ack1),
    .rdata  (rdata),
    .busy   (busy)
`ifdef REG_BANK_ARBITER_PARITY_EN
    ,
    .par_inj(par_inj),
    .perr   (perr)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end
    m_last  = 1'b1;
    m_rdata = '0;
    m_perr  = 1'b0;
    expq.delete();
  endtask

  // Both requesters hold their request lists; contention alternates, a lone requester just runs.
  task automatic model_burst();
    op_t  a0[$], a1[$];
    op_t  o;
    logic w;
    exp_t e;
    a0 = ops0;
    a1 = ops1;
    while (a0.size() > 0 || a1.size() > 0) begin
      if (a0.size() > 0 && a1.size() > 0) w = ~m_last;
      else w = (a1.size() > 0);
      m_last = w;
      o = w ? a1.pop_front() : a0.pop_front();
      if (o.wr) begin
        m_mem[o.addr] = o.wdata;
        m_bad[o.addr] = o.inj;
        m_perr        = 1'b0;
      end else begin
        m_rdata = m_mem[o.addr];
        m_perr  = m_bad[o.addr];
      end
      e.who = w; e.rdata = m_rdata; e.perr = m_perr;
      expq.push_back(e);
    end
  endtask

  task automatic drive_front(input op_t d0[$], input op_t d1[$]);
    req0 = (d0.size() > 0);
    req1 = (d1.size() > 0);
    if (d0.size() > 0) begin wr0 = d0[0].wr; addr0 = d0[0].addr; wdata0 = d0[0].wdata; end
    if (d1.size() > 0) begin wr1 = d1[0].wr; addr1 = d1[0].addr; wdata1 = d1[0].wdata; end
`ifdef REG_BANK_ARBITER_PARITY_EN
    par_inj = (d0.size() > 0) ? d0[0].inj : ((d1.size() > 0) ? d1[0].inj : 1'b0);
`endif
  endtask

  task automatic run_burst();
    op_t d0[$], d1[$];
    int  budget;
    int  cyc;
    model_burst();
    d0 = ops0;
    d1 = ops1;
    budget = 4 * (d0.size() + d1.size()) + 8;
    cyc = 0;
    @(negedge clock);
    drive_front(d0, d1);
    while ((d0.size() > 0 || d1.size() > 0) && cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (ack0 && d0.size() > 0) void'(d0.pop_front());
      if (ack1 && d1.size() > 0) void'(d1.pop_front());
      if (ack0 || ack1) drive_front(d0, d1);
    end
    if (d0.size() > 0 || d1.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL burst_timeout: %0d ops left, expected 0", d0.size() + d1.size());
      req0 = 1'b0;
      req1 = 1'b0;
      expq.delete();
    end
    ops0.delete();
    ops1.delete();
  endtask

  function automatic op_t mk(input logic wr, input int addr, input int data, input logic inj);
    op_t o;
    o.wr = wr; o.addr = AW'(addr); o.wdata = WIDTH'(data); o.inj = inj;
    return o;
  endfunction

  task automatic do_reset();
    clear = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    clear = 1'b1;
  endtask

  int   gnt_run = 0;
  exp_t me;

  always @(negedge clock) begin
    if (!clear) begin
      gnt_run = 0;
    end else begin
      if (gnt0 || gnt1) gnt_run++;
      else gnt_run = 0;
      chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
      chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
      chk("busy_vs_gnt", 32'(busy), 32'(gnt0 | gnt1));
      if (ack0 || ack1) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: ack0=%0b ack1=%0b, expected none", ack0, ack1);
        end else begin
          me = expq.pop_front();
          chk("ack_who", 32'(ack1), 32'(me.who));
          chk("rdata", 32'(rdata), 32'(me.rdata));
          chk("ack_latency", 32'(gnt_run), 32'd2);
`ifdef REG_BANK_ARBITER_PARITY_EN
          chk("perr", 32'(perr), 32'(me.perr));
`endif
        end
      end
    end
  end

  initial begin
    do_reset();
    repeat (3) begin
      @(negedge clock);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
      chk("idle_ack", 32'({ack0, ack1}), 32'd0);
      chk("idle_rdata", 32'(rdata), 32'd0);
    end

    for (int a = 0; a < DEPTH; a++) ops0.push_back(mk(1'b0, a, 0, 1'b0));
    run_burst();

    ops0.push_back(mk(1'b1, 2, 'hA5, 1'b0));
    run_burst();
    ops0.push_back(mk(1'b0, 2, 0, 1'b0));
    run_burst();

    do_reset();
    for (int i = 0; i < 3; i++) begin
      ops0.push_back(mk(1'b1, i, 'h10 + i, 1'b0));
      ops1.push_back(mk(1'b0, i, 0, 1'b0));
    end
    run_burst();

    ops0.push_back(mk(1'b0, 0, 0, 1'b0));
    run_burst();
    ops1.push_back(mk(1'b1, 3, 'h3C, 1'b0));
    ops0.push_back(mk(1'b0, 3, 0, 1'b0));
    run_burst();

    @(negedge clock);
    req0 = 1'b1; wr0 = 1'b1; addr0 = 2'd1; wdata0 = 8'hFF;
    @(posedge clock);
    #2;
    chk("mid_busy_before_clear", 32'(busy), 32'd1);
    clear = 1'b0;
    #1;
    chk("mid_busy_after_clear", 32'(busy), 32'd0);
    chk("mid_gnt_after_clear", 32'({gnt0, gnt1}), 32'd0);
    chk("mid_ack_after_clear", 32'({ack0, ack1}), 32'd0);
    chk("mid_rdata_after_clear", 32'(rdata), 32'd0);
    req0 = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    clear = 1'b1;
    ops0.push_back(mk(1'b0, 1, 0, 1'b0));
    run_burst();

`ifdef REG_BANK_ARBITER_PARITY_EN
    ops0.push_back(mk(1'b1, 0, 'h0F, 1'b1));
    run_burst();
    ops0.push_back(mk(1'b0, 0, 0, 1'b0));
    run_burst();
    ops0.push_back(mk(1'b1, 0, 'h0F, 1'b0));
    run_burst();
    ops0.push_back(mk(1'b0, 0, 0, 1'b0));
    run_burst();
`endif

    for (int b = 0; b < 200; b++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++)
        ops0.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255), 1'b0));
      for (int i = 0; i < n1; i++)
        ops1.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255), 1'b0));
      run_burst();
    end

    repeat (4) @(negedge clock);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
